// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame constants.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int BAUD_DIV_MIN   = 4;

endpackage

// File: rtl/uart_rx_fifo_rx_byte_fifo.sv
// Synchronous byte FIFO with a registered head output. A push into a full FIFO
// is accepted when a pop happens in the same cycle; otherwise it is dropped.
module rx_byte_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             push_drop,
    output logic [WIDTH-1:0] head_q
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign push_drop = push && !push_ok;

    // Storage array; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Pointers and popped-byte register. On a full push+pop the read sees the
    // old head before the write lands in the same slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                head_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO; host pops with a level-toggle handshake.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] baud_div,
    input  logic        uart_rx_pin,
    input  logic        uart_rx_read,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_rx_byte,
    output logic        uart_rx_overflow,
    output logic        uart_rx_frame_err
);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rx_s;
    logic                      read_q;
    logic                      pop;
    rx_state_e                 state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] sr_q, sr_d;
    logic                      fire;
    logic                      push;
    logic                      ferr;
    logic                      push_drop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [15:0]               half_div;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign pop      = (uart_rx_read != read_q);
    assign fire     = (cnt_q == 16'd0);
    assign half_div = {1'b0, baud_div[15:1]};

    // RX pin synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_pin};
    end

    // Toggle history; loaded from the pin in reset too so release never pops.
    always_ff @(posedge clk) begin
        read_q <= uart_rx_read;
    end

    // Receiver state, baud counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
        end
    end

    // Next-state logic: start verified at half a bit, then one sample per bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 16'd1;
        bit_d   = bit_q;
        sr_d    = sr_q;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = half_div - 16'd1;
                end
            end
            RX_START: begin
                if (fire) begin
                    if (!rx_s) begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                        cnt_d   = baud_div - 16'd1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (fire) begin
                    sr_d  = {rx_s, sr_q[UART_DATA_BITS-1:1]};
                    cnt_d = baud_div - 16'd1;
                    if (bit_q == 3'(UART_DATA_BITS-1)) state_d = RX_STOP;
                    else                               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (fire) begin
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Error pulses, registered so they line up with the ready rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uart_rx_overflow  <= 1'b0;
            uart_rx_frame_err <= 1'b0;
        end else begin
            uart_rx_overflow  <= push_drop;
            uart_rx_frame_err <= ferr;
        end
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (sr_q),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (push_drop),
        .head_q    (uart_rx_byte)
    );

    assign uart_rx_ready = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: bit-bangs 8N1 frames on the RX pin and
// checks popped bytes, ready and the error pulses against a queue model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div;
    logic        uart_rx_pin = 1'b1;
    logic        uart_rx_read = 1'b0;
    logic        uart_rx_ready;
    logic [7:0]  uart_rx_byte;
    logic        uart_rx_overflow;
    logic        uart_rx_frame_err;

    int          bd = 16;
    int          n_cmp = 0;
    int          n_err = 0;
    int          ovf_cnt = 0;
    int          ferr_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_exp = 8'h00;

    assign baud_div = 16'(bd);

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .baud_div          (baud_div),
        .uart_rx_pin       (uart_rx_pin),
        .uart_rx_read      (uart_rx_read),
        .uart_rx_ready     (uart_rx_ready),
        .uart_rx_byte      (uart_rx_byte),
        .uart_rx_overflow  (uart_rx_overflow),
        .uart_rx_frame_err (uart_rx_frame_err)
    );

    always #10 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (uart_rx_overflow)  ovf_cnt++;
            if (uart_rx_frame_err) ferr_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx_pin = 1'b0;
        repeat (bd) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            repeat (bd) @(negedge clk);
        end
        uart_rx_pin = stop;
        repeat (bd) @(negedge clk);
        uart_rx_pin = 1'b1;
    endtask

    // Good frame; the model keeps it only if the FIFO has room.
    task automatic send_good(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic do_pop();
        @(negedge clk);
        uart_rx_read = ~uart_rx_read;
        @(negedge clk);
        if (exp_q.size() > 0) last_exp = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", uart_rx_ready); end
        n_cmp++; if (uart_rx_byte !== 8'h00) begin n_err++; $display("FAIL reset_byte: got %h want 00", uart_rx_byte); end
        n_cmp++; if (uart_rx_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", uart_rx_overflow); end
        n_cmp++; if (uart_rx_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", uart_rx_frame_err); end
    endtask

    task automatic test_single();
        fork
            send_good(8'hA5);
            begin
                @(negedge clk);
                repeat (150) @(negedge clk);
                n_cmp++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL single_early_ready: got %b want 0", uart_rx_ready); end
                repeat (6) @(negedge clk);
                n_cmp++; if (uart_rx_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", uart_rx_ready); end
            end
        join
        do_pop();
        n_cmp++; if (uart_rx_byte !== last_exp) begin n_err++; $display("FAIL single_byte: got %h want %h", uart_rx_byte, last_exp); end
        n_cmp++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_after_pop: got %b want 0", uart_rx_ready); end
    endtask

    task automatic test_overflow();
        int ovf0;
        ovf0 = ovf_cnt;
        for (int i = 0; i <= DEPTH; i++) send_good(8'(i));
        repeat (4) @(negedge clk);
        n_cmp++; if (ovf_cnt - ovf0 !== 1) begin n_err++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - ovf0); end
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            n_cmp++; if (uart_rx_byte !== last_exp) begin n_err++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, uart_rx_byte, last_exp); end
        end
        n_cmp++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL ovf_empty_ready: got %b want 0", uart_rx_ready); end
        do_pop();
        n_cmp++; if (uart_rx_byte !== 8'h3F) begin n_err++; $display("FAIL pop_empty_byte: got %h want 3f", uart_rx_byte); end
    endtask

    task automatic test_frame_err();
        int ferr0;
        ferr0 = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        uart_rx_pin = 1'b0;
        repeat (20 * bd) @(negedge clk);
        n_cmp++; if (ferr_cnt - ferr0 !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - ferr0); end
        n_cmp++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL ferr_ready: got %b want 0", uart_rx_ready); end
        uart_rx_pin = 1'b1;
        repeat (2 * bd) @(negedge clk);
        send_good(8'h11);
        do_pop();
        n_cmp++; if (uart_rx_byte !== last_exp) begin n_err++; $display("FAIL ferr_recover: got %h want %h", uart_rx_byte, last_exp); end
    endtask

    task automatic test_glitch();
        int ferr0;
        ferr0 = ferr_cnt;
        @(negedge clk);
        uart_rx_pin = 1'b0;
        repeat (bd / 4) @(negedge clk);
        uart_rx_pin = 1'b1;
        repeat (3 * bd) @(negedge clk);
        n_cmp++; if (ferr_cnt !== ferr0) begin n_err++; $display("FAIL glitch_ferr: got %0d want %0d", ferr_cnt, ferr0); end
        n_cmp++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL glitch_ready: got %b want 0", uart_rx_ready); end
        send_good(8'h7E);
        do_pop();
        n_cmp++; if (uart_rx_byte !== last_exp) begin n_err++; $display("FAIL glitch_next: got %h want %h", uart_rx_byte, last_exp); end
    endtask

    task automatic test_alt_baud();
        bd = 7;
        repeat (4) @(negedge clk);
        send_good(8'hC3);
        do_pop();
        n_cmp++; if (uart_rx_byte !== last_exp) begin n_err++; $display("FAIL alt_baud: got %h want %h", uart_rx_byte, last_exp); end
        bd = 16;
        repeat (4) @(negedge clk);
    endtask

    // Full FIFO, last byte's stop sample coincides with a pop toggle.
    task automatic test_full_push_pop();
        int         ovf0;
        logic [7:0] nb;
        logic [7:0] head;
        for (int i = 0; i < DEPTH; i++) send_good(8'($urandom_range(0, 255)));
        ovf0 = ovf_cnt;
        nb   = 8'h5A;
        head = exp_q.pop_front();
        exp_q.push_back(nb);
        fork
            send_byte(nb, 1'b1);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                uart_rx_read = ~uart_rx_read;
            end
        join
        repeat (4) @(negedge clk);
        n_cmp++; if (ovf_cnt !== ovf0) begin n_err++; $display("FAIL same_clk_ovf: got %0d want %0d", ovf_cnt, ovf0); end
        n_cmp++; if (uart_rx_byte !== head) begin n_err++; $display("FAIL same_clk_head: got %h want %h", uart_rx_byte, head); end
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            n_cmp++; if (uart_rx_byte !== last_exp) begin n_err++; $display("FAIL full_drain[%0d]: got %h want %h", i, uart_rx_byte, last_exp); end
        end
        n_cmp++; if (uart_rx_byte !== nb) begin n_err++; $display("FAIL full_last: got %h want %h", uart_rx_byte, nb); end
    endtask

    task automatic test_reset_mid_frame();
        send_good(8'h99);
        send_good(8'h42);
        do_pop();
        @(negedge clk);
        uart_rx_pin = 1'b0;
        repeat (3 * bd) @(negedge clk);
        uart_rx_pin = 1'b1;
        repeat (bd) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        last_exp = 8'h00;
        n_cmp++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", uart_rx_ready); end
        n_cmp++; if (uart_rx_byte !== 8'h00) begin n_err++; $display("FAIL midrst_byte: got %h want 00", uart_rx_byte); end
        n_cmp++; if (uart_rx_overflow !== 1'b0 || uart_rx_frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_pulses: got %b%b want 00", uart_rx_overflow, uart_rx_frame_err); end
        repeat (12 * bd) @(negedge clk);
        n_cmp++; if (uart_rx_ready !== 1'b0) begin n_err++; $display("FAIL midrst_no_push: got %b want 0", uart_rx_ready); end
        send_good(8'hE7);
        do_pop();
        n_cmp++; if (uart_rx_byte !== last_exp) begin n_err++; $display("FAIL midrst_next: got %h want %h", uart_rx_byte, last_exp); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_alt_baud();
        test_full_push_pop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
